// File: rtl/regfile_read_stage_mp_if.sv
// Issue/execute/writeback bundle for the multi-lane operand-read stage.
interface regfile_read_stage_mp_if #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NREG      = 32,
   parameter int unsigned PAYLOAD_W = 48
);
   localparam int unsigned AW = $clog2(NREG);

   logic                           flush;
   logic [NUM_WR-1:0]              wr_en;
   logic [NUM_WR*AW-1:0]           wr_addr;
   logic [NUM_WR*XLEN-1:0]         wr_data;
   logic [2*XLEN-1:0]              stable_cnt;

   logic [NUM_LANES-1:0]           in_valid;
   logic                           in_ready;
   logic [2*NUM_LANES-1:0]         in_src1_sel;
   logic [2*NUM_LANES-1:0]         in_src2_sel;
   logic [AW*NUM_LANES-1:0]        in_rj;
   logic [AW*NUM_LANES-1:0]        in_rk;
   logic [XLEN*NUM_LANES-1:0]      in_pc;
   logic [XLEN*NUM_LANES-1:0]      in_imm;
   logic [PAYLOAD_W*NUM_LANES-1:0] in_payload;

   logic [NUM_LANES-1:0]           out_valid;
   logic                           out_ready;
   logic [XLEN*NUM_LANES-1:0]      out_op1;
   logic [XLEN*NUM_LANES-1:0]      out_op2;
   logic [AW*NUM_LANES-1:0]        out_rj;
   logic [AW*NUM_LANES-1:0]        out_rk;
   logic [XLEN*NUM_LANES-1:0]      out_pc;
   logic [XLEN*NUM_LANES-1:0]      out_imm;
   logic [PAYLOAD_W*NUM_LANES-1:0] out_payload;

   modport master (
      output flush, wr_en, wr_addr, wr_data, stable_cnt,
      output in_valid, in_src1_sel, in_src2_sel, in_rj, in_rk, in_pc, in_imm, in_payload,
      output out_ready,
      input  in_ready,
      input  out_valid, out_op1, out_op2, out_rj, out_rk, out_pc, out_imm, out_payload
   );

   modport slave (
      input  flush, wr_en, wr_addr, wr_data, stable_cnt,
      input  in_valid, in_src1_sel, in_src2_sel, in_rj, in_rk, in_pc, in_imm, in_payload,
      input  out_ready,
      output in_ready,
      output out_valid, out_op1, out_op2, out_rj, out_rk, out_pc, out_imm, out_payload
   );
endinterface

// File: rtl/regfile_read_stage_mp.sv
// Multi-lane register file with writeback forwarding and a single registered operand stage.
module regfile_read_stage_mp #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NREG      = 32,
   parameter int unsigned PAYLOAD_W = 48
) (
   input logic                    clk,
   input logic                    rstn,
   regfile_read_stage_mp_if.slave bus
);
   localparam int unsigned AW = $clog2(NREG);

   logic [XLEN-1:0]                rf_q [NREG];

   logic [NUM_LANES-1:0]           out_valid_q,   out_valid_d;
   logic [XLEN*NUM_LANES-1:0]      out_op1_q,     out_op1_d;
   logic [XLEN*NUM_LANES-1:0]      out_op2_q,     out_op2_d;
   logic [AW*NUM_LANES-1:0]        out_rj_q,      out_rj_d;
   logic [AW*NUM_LANES-1:0]        out_rk_q,      out_rk_d;
   logic [XLEN*NUM_LANES-1:0]      out_pc_q,      out_pc_d;
   logic [XLEN*NUM_LANES-1:0]      out_imm_q,     out_imm_d;
   logic [PAYLOAD_W*NUM_LANES-1:0] out_payload_q, out_payload_d;
   logic [2*NUM_LANES-1:0]         src1_sel_q,    src1_sel_d;
   logic [2*NUM_LANES-1:0]         src2_sel_q,    src2_sel_d;

   logic                           in_ready;

   // {hit, data} of the highest writeback port targeting idx; x0 never hits
   function automatic logic [XLEN:0] wb_match(
      input logic [AW-1:0]        idx,
      input logic [NUM_WR-1:0]    en,
      input logic [NUM_WR*AW-1:0] addr,
      input logic [NUM_WR*XLEN-1:0] data
   );
      logic [XLEN:0] r;
      r = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (en[p] && (addr[p*AW +: AW] == idx) && (idx != '0)) begin
            r = {1'b1, data[p*XLEN +: XLEN]};
         end
      end
      return r;
   endfunction

   // Register array: later ports overwrite earlier ones on the same address
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0)) begin
               rf_q[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
            end
         end
      end
   end

   assign in_ready = ~|out_valid_q | bus.out_ready;

   // Output-stage next state: flush, else capture, else hold with writeback snoop
   always_comb begin
      logic [AW-1:0]   rj, rk;
      logic [1:0]      s1, s2;
      logic [XLEN:0]   m1, m2;
      logic [XLEN-1:0] v1, v2;

      rj = '0;
      rk = '0;
      s1 = '0;
      s2 = '0;
      m1 = '0;
      m2 = '0;
      v1 = '0;
      v2 = '0;

      out_valid_d   = out_valid_q;
      out_op1_d     = out_op1_q;
      out_op2_d     = out_op2_q;
      out_rj_d      = out_rj_q;
      out_rk_d      = out_rk_q;
      out_pc_d      = out_pc_q;
      out_imm_d     = out_imm_q;
      out_payload_d = out_payload_q;
      src1_sel_d    = src1_sel_q;
      src2_sel_d    = src2_sel_q;

      if (bus.flush) begin
         out_valid_d = '0;
      end else if (in_ready) begin
         out_valid_d   = bus.in_valid;
         out_rj_d      = bus.in_rj;
         out_rk_d      = bus.in_rk;
         out_pc_d      = bus.in_pc;
         out_imm_d     = bus.in_imm;
         out_payload_d = bus.in_payload;
         src1_sel_d    = bus.in_src1_sel;
         src2_sel_d    = bus.in_src2_sel;
         for (int l = 0; l < NUM_LANES; l++) begin
            rj = bus.in_rj[l*AW +: AW];
            rk = bus.in_rk[l*AW +: AW];
            s1 = bus.in_src1_sel[2*l +: 2];
            s2 = bus.in_src2_sel[2*l +: 2];
            m1 = wb_match(rj, bus.wr_en, bus.wr_addr, bus.wr_data);
            m2 = wb_match(rk, bus.wr_en, bus.wr_addr, bus.wr_data);

            if (rj == '0)       v1 = '0;
            else if (m1[XLEN])  v1 = m1[XLEN-1:0];
            else                v1 = rf_q[rj];

            if (rk == '0)       v2 = '0;
            else if (m2[XLEN])  v2 = m2[XLEN-1:0];
            else                v2 = rf_q[rk];

            case (s1)
               2'd0:    out_op1_d[l*XLEN +: XLEN] = v1;
               2'd1:    out_op1_d[l*XLEN +: XLEN] = bus.in_pc[l*XLEN +: XLEN];
               default: out_op1_d[l*XLEN +: XLEN] = '0;
            endcase

            case (s2)
               2'd0:    out_op2_d[l*XLEN +: XLEN] = v2;
               2'd1:    out_op2_d[l*XLEN +: XLEN] = bus.in_imm[l*XLEN +: XLEN];
               2'd2:    out_op2_d[l*XLEN +: XLEN] = bus.stable_cnt[XLEN-1:0];
               default: out_op2_d[l*XLEN +: XLEN] = bus.stable_cnt[2*XLEN-1:XLEN];
            endcase
         end
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            m1 = wb_match(out_rj_q[l*AW +: AW], bus.wr_en, bus.wr_addr, bus.wr_data);
            m2 = wb_match(out_rk_q[l*AW +: AW], bus.wr_en, bus.wr_addr, bus.wr_data);
            if ((src1_sel_q[2*l +: 2] == 2'd0) && m1[XLEN]) begin
               out_op1_d[l*XLEN +: XLEN] = m1[XLEN-1:0];
            end
            if ((src2_sel_q[2*l +: 2] == 2'd0) && m2[XLEN]) begin
               out_op2_d[l*XLEN +: XLEN] = m2[XLEN-1:0];
            end
         end
      end
   end

   // Output-stage registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid_q   <= '0;
         out_op1_q     <= '0;
         out_op2_q     <= '0;
         out_rj_q      <= '0;
         out_rk_q      <= '0;
         out_pc_q      <= '0;
         out_imm_q     <= '0;
         out_payload_q <= '0;
         src1_sel_q    <= '0;
         src2_sel_q    <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_op1_q     <= out_op1_d;
         out_op2_q     <= out_op2_d;
         out_rj_q      <= out_rj_d;
         out_rk_q      <= out_rk_d;
         out_pc_q      <= out_pc_d;
         out_imm_q     <= out_imm_d;
         out_payload_q <= out_payload_d;
         src1_sel_q    <= src1_sel_d;
         src2_sel_q    <= src2_sel_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_op1     = out_op1_q;
   assign bus.out_op2     = out_op2_q;
   assign bus.out_rj      = out_rj_q;
   assign bus.out_rk      = out_rk_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_imm     = out_imm_q;
   assign bus.out_payload = out_payload_q;
endmodule
